main_ctrl_fsm: RTL and testbench

- Multicycle RV32I main control FSM. It sequences fetch, decode, execute, memory and writeback over a shared ALU, register file and unified memory.
- It drives the 2-bit immediate-type select of the immediate extender, plus all datapath mux/enable controls.
- It uses a done-handshake with the memory interface, so fetch and load/store may take any number of cycles.

---
 rtl/main_ctrl_fsm_pkg.sv | 78 +++++++
 rtl/main_ctrl_fsm_op_decode.sv | 42 ++++
 rtl/main_ctrl_fsm.sv | 156 +++++++++++++++
 tb/tb_main_ctrl_fsm.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/main_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states,
// opcodes and the datapath mux/ALU select codes.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEMADR    = 4'd3,
        S_MEMREAD   = 4'd4,
        S_MEMWB     = 4'd5,
        S_MEMWRITE  = 4'd6,
        S_EXECR     = 4'd7,
        S_EXECI     = 4'd8,
        S_ALUWB     = 4'd9,
        S_BRANCH    = 4'd10,
        S_JAL       = 4'd11,
        S_JALR_CALC = 4'd12,
        S_JALR_JMP  = 4'd13,
        S_TRAP      = 4'd14
    } t_state;

    typedef struct packed {
        logic load;
        logic store;
        logic rtype;
        logic itype;
        logic branch;
        logic jal;
        logic jalr;
        logic illegal;
    } t_op_cls;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       instr_write;
        logic       adr_src;
        logic       mem_read_req;
        logic       mem_write_req;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal;
    } t_ctrl;

endpackage

// File: rtl/main_ctrl_fsm_op_decode.sv
// Opcode classifier: immediate-type select plus a one-hot instruction class
// used by the control FSM's DECODE transition.
module op_decode
    import riscv_ctrl_pkg::*;
#(
    parameter int OP_WIDTH = 7
) (
    input  logic [OP_WIDTH-1:0] i_op,
    output logic [1:0]          o_imm_src,
    output t_op_cls             o_cls
);

    logic [6:0] op;

    assign op = 7'(i_op);

    always_comb begin
        o_cls = '0;
        case (op)
            OP_LOAD:   o_cls.load    = 1'b1;
            OP_STORE:  o_cls.store   = 1'b1;
            OP_RTYPE:  o_cls.rtype   = 1'b1;
            OP_ITYPE:  o_cls.itype   = 1'b1;
            OP_BRANCH: o_cls.branch  = 1'b1;
            OP_JAL:    o_cls.jal     = 1'b1;
            OP_JALR:   o_cls.jalr    = 1'b1;
            default:   o_cls.illegal = 1'b1;
        endcase
    end

    // Unknown opcodes fall back to the I-type extender; harmless since they trap.
    always_comb begin
        o_imm_src = IMM_I;
        case (op)
            OP_STORE:  o_imm_src = IMM_S;
            OP_BRANCH: o_imm_src = IMM_B;
            OP_JAL:    o_imm_src = IMM_J;
            default:   o_imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/main_ctrl_fsm.sv
// Multicycle RV32I main control FSM: sequences fetch/decode/execute/mem/wb
// over a shared ALU and unified memory with a done-handshake.
module main_ctrl_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int OP_WIDTH = 7
) (
    input  logic                clk,
    input  logic                arstn,
    input  logic [OP_WIDTH-1:0] i_op,
    input  logic                i_mem_done,
    output logic [1:0]          o_imm_src,
    output logic                o_pc_write,
    output logic                o_branch,
    output logic                o_instr_write,
    output logic                o_adr_src,
    output logic                o_mem_read_req,
    output logic                o_mem_write_req,
    output logic                o_reg_write,
    output logic [1:0]          o_result_src,
    output logic [1:0]          o_alu_src_a,
    output logic [1:0]          o_alu_src_b,
    output logic [1:0]          o_alu_op,
    output logic                o_illegal
);

    t_state  state, state_nxt;
    t_op_cls cls;
    t_ctrl   ctrl;

    op_decode #(.OP_WIDTH(OP_WIDTH)) u_op_decode (
        .i_op      (i_op),
        .o_imm_src (o_imm_src),
        .o_cls     (cls)
    );

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      state_nxt = S_FETCH;
            S_FETCH:     if (i_mem_done) state_nxt = S_DECODE;
            S_DECODE: begin
                if (cls.load || cls.store) state_nxt = S_MEMADR;
                else if (cls.rtype)        state_nxt = S_EXECR;
                else if (cls.itype)        state_nxt = S_EXECI;
                else if (cls.branch)       state_nxt = S_BRANCH;
                else if (cls.jal)          state_nxt = S_JAL;
                else if (cls.jalr)         state_nxt = S_JALR_CALC;
                else                       state_nxt = S_TRAP;
            end
            S_MEMADR:    state_nxt = cls.load ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:   if (i_mem_done) state_nxt = S_MEMWB;
            S_MEMWB:     state_nxt = S_FETCH;
            S_MEMWRITE:  if (i_mem_done) state_nxt = S_FETCH;
            S_EXECR:     state_nxt = S_ALUWB;
            S_EXECI:     state_nxt = S_ALUWB;
            S_ALUWB:     state_nxt = S_FETCH;
            S_BRANCH:    state_nxt = S_FETCH;
            S_JAL:       state_nxt = S_ALUWB;
            S_JALR_CALC: state_nxt = S_JALR_JMP;
            S_JALR_JMP:  state_nxt = S_ALUWB;
            S_TRAP:      state_nxt = S_TRAP;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                // PC+4 lands in PC on the same cycle the instruction is latched.
                ctrl.mem_read_req = 1'b1;
                ctrl.adr_src      = 1'b0;
                ctrl.alu_src_a    = SRCA_PC;
                ctrl.alu_src_b    = SRCB_FOUR;
                ctrl.alu_op       = ALUOP_ADD;
                ctrl.result_src   = RES_ALURES;
                ctrl.pc_write     = i_mem_done;
                ctrl.instr_write  = i_mem_done;
            end
            S_DECODE: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR, S_JALR_CALC: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl.mem_read_req = 1'b1;
                ctrl.adr_src      = 1'b1;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_RDATA;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.mem_write_req = 1'b1;
                ctrl.adr_src       = 1'b1;
                ctrl.result_src    = RES_ALUOUT;
            end
            S_EXECR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.branch     = 1'b1;
            end
            S_JAL, S_JALR_JMP: begin
                // ALUOut already holds the target; ALU forms OldPC+4 for the link.
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = 1'b1;
            end
            S_TRAP:  ctrl.illegal = 1'b1;
            default: ctrl = '0;
        endcase
    end

    assign o_pc_write      = ctrl.pc_write;
    assign o_branch        = ctrl.branch;
    assign o_instr_write   = ctrl.instr_write;
    assign o_adr_src       = ctrl.adr_src;
    assign o_mem_read_req  = ctrl.mem_read_req;
    assign o_mem_write_req = ctrl.mem_write_req;
    assign o_reg_write     = ctrl.reg_write;
    assign o_result_src    = ctrl.result_src;
    assign o_alu_src_a     = ctrl.alu_src_a;
    assign o_alu_src_b     = ctrl.alu_src_b;
    assign o_alu_op        = ctrl.alu_op;
    assign o_illegal       = ctrl.illegal;

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Directed bench for main_ctrl_fsm: walks each instruction class cycle by
// cycle and compares every control output against hand-derived vectors.
module tb_main_ctrl_fsm;

    logic       clk;
    logic       arstn;
    logic [6:0] i_op;
    logic       i_mem_done;
    logic [1:0] o_imm_src;
    logic       o_pc_write, o_branch, o_instr_write, o_adr_src;
    logic       o_mem_read_req, o_mem_write_req, o_reg_write, o_illegal;
    logic [1:0] o_result_src, o_alu_src_a, o_alu_src_b, o_alu_op;

    int n_chk = 0;
    int n_err = 0;

    main_ctrl_fsm #(.OP_WIDTH(7)) dut (
        .clk             (clk),
        .arstn           (arstn),
        .i_op            (i_op),
        .i_mem_done      (i_mem_done),
        .o_imm_src       (o_imm_src),
        .o_pc_write      (o_pc_write),
        .o_branch        (o_branch),
        .o_instr_write   (o_instr_write),
        .o_adr_src       (o_adr_src),
        .o_mem_read_req  (o_mem_read_req),
        .o_mem_write_req (o_mem_write_req),
        .o_reg_write     (o_reg_write),
        .o_result_src    (o_result_src),
        .o_alu_src_a     (o_alu_src_a),
        .o_alu_src_b     (o_alu_src_b),
        .o_alu_op        (o_alu_op),
        .o_illegal       (o_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_write, branch, instr_write, adr_src, mrd, mwr, reg_write,
    //  result_src[1:0], a[1:0], b[1:0], alu_op[1:0], illegal}
    logic [15:0] ctl_obs;
    assign ctl_obs = {o_pc_write, o_branch, o_instr_write, o_adr_src,
                      o_mem_read_req, o_mem_write_req, o_reg_write,
                      o_result_src, o_alu_src_a, o_alu_src_b, o_alu_op, o_illegal};

    function automatic logic [15:0] mk(input logic pcw, input logic br, input logic iw,
                                       input logic adr, input logic mr, input logic mw,
                                       input logic rw, input logic [1:0] rs,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] aop, input logic ill);
        return {pcw, br, iw, adr, mr, mw, rw, rs, a, b, aop, ill};
    endfunction

    localparam logic [15:0] E_IDLE   = 16'h0000;
    logic [15:0] e_fetch0, e_fetch1, e_decode, e_memadr, e_memread, e_memwb, e_memwrite;
    logic [15:0] e_execr, e_execi, e_aluwb, e_branch, e_jal, e_jalr_calc, e_trap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Check one state cycle (with done applied), then advance to the next cycle.
    task automatic cyc(input string tag, input logic done, input logic [15:0] ec,
                       input logic [1:0] ei);
        i_mem_done = done;
        #1;
        chk({tag, ".ctl"}, 32'(ctl_obs), 32'(ec));
        chk({tag, ".imm"}, 32'(o_imm_src), 32'(ei));
        @(posedge clk);
        #1;
    endtask

    initial begin
        e_fetch0    = mk(0,0,0,0,1,0,0,2'b10,2'b00,2'b10,2'b00,0);
        e_fetch1    = mk(1,0,1,0,1,0,0,2'b10,2'b00,2'b10,2'b00,0);
        e_decode    = mk(0,0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,0);
        e_memadr    = mk(0,0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0);
        e_memread   = mk(0,0,0,1,1,0,0,2'b00,2'b00,2'b00,2'b00,0);
        e_memwb     = mk(0,0,0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,0);
        e_memwrite  = mk(0,0,0,1,0,1,0,2'b00,2'b00,2'b00,2'b00,0);
        e_execr     = mk(0,0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,0);
        e_execi     = mk(0,0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,0);
        e_aluwb     = mk(0,0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0);
        e_branch    = mk(0,1,0,0,0,0,0,2'b00,2'b10,2'b00,2'b01,0);
        e_jal       = mk(1,0,0,0,0,0,0,2'b00,2'b01,2'b10,2'b00,0);
        e_jalr_calc = mk(0,0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0);
        e_trap      = mk(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1);

        arstn      = 1'b1;
        i_op       = 7'b0000000;
        i_mem_done = 1'b0;
        #3 arstn = 1'b0;
        @(posedge clk); #1;
        chk("rst.ctl", 32'(ctl_obs), 32'(E_IDLE));
        i_op = 7'b1101111;
        #1;
        chk("rst.imm_jal", 32'(o_imm_src), 32'd3);
        @(posedge clk); #1;
        arstn = 1'b1;

        // lw with two wait cycles in FETCH and MEMREAD; a stray done in DECODE is ignored
        i_op = 7'b0000011;
        cyc("idle",      0, E_IDLE,    2'b00);
        cyc("lw.f0",     0, e_fetch0,  2'b00);
        cyc("lw.f1",     0, e_fetch0,  2'b00);
        cyc("lw.f2",     1, e_fetch1,  2'b00);
        cyc("lw.dec",    1, e_decode,  2'b00);
        cyc("lw.adr",    0, e_memadr,  2'b00);
        cyc("lw.rd0",    0, e_memread, 2'b00);
        cyc("lw.rd1",    0, e_memread, 2'b00);
        cyc("lw.rd2",    1, e_memread, 2'b00);
        cyc("lw.wb",     0, e_memwb,   2'b00);

        i_op = 7'b0100011;
        cyc("sw.f",      1, e_fetch1,   2'b01);
        cyc("sw.dec",    0, e_decode,   2'b01);
        cyc("sw.adr",    0, e_memadr,   2'b01);
        cyc("sw.wr",     1, e_memwrite, 2'b01);

        i_op = 7'b1100011;
        cyc("beq.f",     1, e_fetch1, 2'b10);
        cyc("beq.dec",   0, e_decode, 2'b10);
        cyc("beq.br",    0, e_branch, 2'b10);

        i_op = 7'b1101111;
        cyc("jal.f",     1, e_fetch1, 2'b11);
        cyc("jal.dec",   0, e_decode, 2'b11);
        cyc("jal.jmp",   0, e_jal,    2'b11);
        cyc("jal.wb",    0, e_aluwb,  2'b11);

        i_op = 7'b1100111;
        cyc("jalr.f",    1, e_fetch1,    2'b00);
        cyc("jalr.dec",  0, e_decode,    2'b00);
        cyc("jalr.calc", 0, e_jalr_calc, 2'b00);
        cyc("jalr.jmp",  0, e_jal,       2'b00);
        cyc("jalr.wb",   0, e_aluwb,     2'b00);

        i_op = 7'b0110011;
        cyc("r.f",       1, e_fetch1, 2'b00);
        cyc("r.dec",     0, e_decode, 2'b00);
        cyc("r.ex",      0, e_execr,  2'b00);
        cyc("r.wb",      0, e_aluwb,  2'b00);

        i_op = 7'b0010011;
        cyc("i.f",       1, e_fetch1, 2'b00);
        cyc("i.dec",     0, e_decode, 2'b00);
        cyc("i.ex",      0, e_execi,  2'b00);
        cyc("i.wb",      0, e_aluwb,  2'b00);

        // Reset asserted in the middle of a MEMREAD wait
        i_op = 7'b0000011;
        cyc("lw2.f",     1, e_fetch1,  2'b00);
        cyc("lw2.dec",   0, e_decode,  2'b00);
        cyc("lw2.adr",   0, e_memadr,  2'b00);
        i_mem_done = 1'b0;
        #1;
        chk("lw2.rd.ctl", 32'(ctl_obs), 32'(e_memread));
        #1 arstn = 1'b0;
        #1;
        chk("midrst.ctl", 32'(ctl_obs), 32'(E_IDLE));
        chk("midrst.imm", 32'(o_imm_src), 32'd0);
        @(posedge clk); #1;
        arstn = 1'b1;
        cyc("rel.idle",  0, E_IDLE,   2'b00);
        cyc("rel.f",     0, e_fetch0, 2'b00);

        // Illegal opcode traps; done pulses change nothing; reset recovers
        i_op = 7'b0000000;
        cyc("ill.f",     1, e_fetch1, 2'b00);
        cyc("ill.dec",   0, e_decode, 2'b00);
        for (int i = 0; i < 20; i++) begin
            cyc("trap", i[0], e_trap, 2'b00);
        end
        arstn = 1'b0;
        #1;
        chk("trap.rst.ctl", 32'(ctl_obs), 32'(E_IDLE));
        @(posedge clk); #1;
        arstn = 1'b1;
        cyc("trap.idle", 0, E_IDLE,   2'b00);
        cyc("trap.f",    0, e_fetch0, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
